// File: rtl/jtkicker_pkg.sv
// Shared constants for the Kicker-family object path: the draw engine,
// the object line buffer and the colour mixer all agree on these widths.
package jtkicker_pkg;

    localparam int OBJ_PXLW = 4;
    localparam int LINE_AW  = 8;

    localparam logic [OBJ_PXLW-1:0] TRANSP_DEF = 4'd0;

    // Scan-out x address: mirror the beam position under flip, then shift by
    // the draw-engine latency offset. Wraps modulo the line length.
    function automatic logic [LINE_AW-1:0] line_addr(
        input logic [LINE_AW-1:0] h,
        input logic               flip,
        input logic [LINE_AW-1:0] offset
    );
        return (flip ? ~h : h) + offset;
    endfunction

endpackage

// File: rtl/jtkicker_objlinebuf_bank.sv
// One 256x4 line bank. The read-modify-write port serves the draw engine
// (lookup at one address, commit at another). The scan port reads for
// display and erases a location one clock later.
module jtkicker_objlinebuf_bank
    import jtkicker_pkg::*;
#(
    parameter logic [OBJ_PXLW-1:0] TRANSP = TRANSP_DEF
)(
    input  logic                clk,
    input  logic [LINE_AW-1:0]  rmw_raddr,
    output logic [OBJ_PXLW-1:0] rmw_q,
    input  logic                rmw_we,
    input  logic [LINE_AW-1:0]  rmw_waddr,
    input  logic [OBJ_PXLW-1:0] rmw_din,
    input  logic [LINE_AW-1:0]  scan_raddr,
    output logic [OBJ_PXLW-1:0] scan_q,
    input  logic                erase_en,
    input  logic [LINE_AW-1:0]  erase_addr
);

    logic [OBJ_PXLW-1:0] mem [0:(1<<LINE_AW)-1];

    assign rmw_q  = mem[rmw_raddr];
    assign scan_q = mem[scan_raddr];

    // Erase and commit never target the same bank in normal operation; if
    // they ever did, the draw-engine commit is the later write and wins.
    always_ff @(posedge clk) begin
        if (erase_en) mem[erase_addr] <= TRANSP;
        if (rmw_we)   mem[rmw_waddr]  <= rmw_din;
    end

endmodule

// File: rtl/jtkicker_objlinebuf.sv
// Double-buffered object line buffer. The draw engine fills the write bank
// for the next line while the read bank is scanned out and wiped behind the
// beam, so every bank comes back clean when it turns into the write bank.
module jtkicker_objlinebuf
    import jtkicker_pkg::*;
#(
    parameter logic [8:0]          HOFFSET    = 9'd0,
    parameter logic [OBJ_PXLW-1:0] TRANSP     = TRANSP_DEF,
    parameter bit                  PRIO_FIRST = 1'b1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                pxl_cen,
    input  logic                hinit,
    input  logic                LHBL,
    input  logic [8:0]          hdump,
    input  logic                flip,
    input  logic                wr_en,
    input  logic [LINE_AW-1:0]  wr_addr,
    input  logic [OBJ_PXLW-1:0] wr_pxl,
    output logic [OBJ_PXLW-1:0] pxl
);

    logic                rd_bank;
    logic                hinit_seen;
    logic                valid;
    logic                swap;
    logic                s0_bank;
    logic [OBJ_PXLW-1:0] s0_old;
    logic                fwd_commit;
    logic                fwd_erase;

    logic                s1_valid;
    logic                s1_bank;
    logic [LINE_AW-1:0]  s1_addr;
    logic [OBJ_PXLW-1:0] s1_pxl;
    logic [OBJ_PXLW-1:0] s1_old;
    logic                commit;

    logic                er_valid;
    logic                er_bank;
    logic [LINE_AW-1:0]  er_addr;

    logic [LINE_AW-1:0]  rd_addr;
    logic [OBJ_PXLW-1:0] rmw_q  [0:1];
    logic [OBJ_PXLW-1:0] scan_q [0:1];

    logic                unused_hdump;
    assign unused_hdump = hdump[8];

    assign swap    = pxl_cen & hinit;
    // A write arriving with the swap already belongs to the next line.
    assign s0_bank = swap ? rd_bank : ~rd_bank;
    assign rd_addr = line_addr(hdump[7:0], flip, HOFFSET[7:0]);

    assign commit = s1_valid && (s1_pxl != TRANSP) &&
                    (!PRIO_FIRST || (s1_old == TRANSP));

    // The RAM still holds pre-edge data for anything written this clock, so
    // same-address commits and erases are bypassed into the lookup.
    assign fwd_commit = commit   && (s1_bank == s0_bank) && (s1_addr == wr_addr);
    assign fwd_erase  = er_valid && (er_bank == s0_bank) && (er_addr == wr_addr);
    assign s0_old     = fwd_commit ? s1_pxl :
                        fwd_erase  ? TRANSP : rmw_q[s0_bank];

    // Bank ownership flips every line start; output is unlocked after both
    // banks have had one full read-and-erase pass since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank    <= 1'b0;
            hinit_seen <= 1'b0;
            valid      <= 1'b0;
        end else if (swap) begin
            rd_bank    <= ~rd_bank;
            hinit_seen <= 1'b1;
            if (hinit_seen) valid <= 1'b1;
        end
    end

    // Write pipeline: stage 0 captures the request, bank and stored pixel;
    // stage 1 commits into the bank fixed at stage 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_bank  <= 1'b0;
            s1_addr  <= '0;
            s1_pxl   <= '0;
            s1_old   <= '0;
        end else begin
            s1_valid <= wr_en;
            if (wr_en) begin
                s1_bank <= s0_bank;
                s1_addr <= wr_addr;
                s1_pxl  <= wr_pxl;
                s1_old  <= s0_old;
            end
        end
    end

    // Scan-out with erase one clock behind; the erase keeps the bank it
    // captured even if a swap lands in between.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pxl      <= TRANSP;
            er_valid <= 1'b0;
            er_bank  <= 1'b0;
            er_addr  <= '0;
        end else begin
            er_valid <= 1'b0;
            if (pxl_cen) begin
                if (LHBL) begin
                    pxl      <= valid ? scan_q[rd_bank] : TRANSP;
                    er_valid <= 1'b1;
                    er_bank  <= rd_bank;
                    er_addr  <= rd_addr;
                end else begin
                    pxl <= TRANSP;
                end
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        jtkicker_objlinebuf_bank #(
            .TRANSP (TRANSP)
        ) u_bank (
            .clk        (clk),
            .rmw_raddr  (wr_addr),
            .rmw_q      (rmw_q[b]),
            .rmw_we     (commit && (s1_bank == 1'(b))),
            .rmw_waddr  (s1_addr),
            .rmw_din    (s1_pxl),
            .scan_raddr (rd_addr),
            .scan_q     (scan_q[b]),
            .erase_en   (er_valid && (er_bank == 1'(b))),
            .erase_addr (er_addr)
        );
    end

endmodule

// File: tb/tb_jtkicker_objlinebuf.sv
// Directed bench: three line buffers share stimulus (default, last-write-wins,
// and HOFFSET=-2) and each scenario task checks the captured scan lines.
module tb_jtkicker_objlinebuf;

    logic       clk = 1'b0;
    logic       rst, pxl_cen, hinit, LHBL, flip, wr_en;
    logic [8:0] hdump;
    logic [7:0] wr_addr;
    logic [3:0] wr_pxl;
    logic [3:0] pxl_a, pxl_b, pxl_c;

    logic [3:0] got_a [0:255];
    logic [3:0] got_b [0:255];
    logic [3:0] got_c [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtkicker_objlinebuf dut_a (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .hinit(hinit), .LHBL(LHBL),
        .hdump(hdump), .flip(flip), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_pxl(wr_pxl), .pxl(pxl_a)
    );

    jtkicker_objlinebuf #(.PRIO_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .hinit(hinit), .LHBL(LHBL),
        .hdump(hdump), .flip(flip), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_pxl(wr_pxl), .pxl(pxl_b)
    );

    jtkicker_objlinebuf #(.HOFFSET(9'h1FE)) dut_c (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .hinit(hinit), .LHBL(LHBL),
        .hdump(hdump), .flip(flip), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_pxl(wr_pxl), .pxl(pxl_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input logic [7:0] a, input logic [3:0] p);
        wr_en = 1'b1; wr_addr = a; wr_pxl = p;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic swap_line();
        pxl_cen = 1'b1; hinit = 1'b1; LHBL = 1'b0;
        tick();
        pxl_cen = 1'b0; hinit = 1'b0;
        tick();
    endtask

    task automatic scan_line();
        for (int h = 0; h < 256; h++) begin
            pxl_cen = 1'b1; LHBL = 1'b1; hdump = 9'(h);
            tick();
            got_a[h] = pxl_a; got_b[h] = pxl_b; got_c[h] = pxl_c;
            pxl_cen = 1'b0;
            tick();
        end
        LHBL = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        rst = 1'b1;
        tick(); tick();
        checks++; if (pxl_a !== 4'd0) begin errors++; $display("FAIL reset_pxl_a got %0d exp 0", pxl_a); end
        checks++; if (pxl_b !== 4'd0) begin errors++; $display("FAIL reset_pxl_b got %0d exp 0", pxl_b); end
        checks++; if (pxl_c !== 4'd0) begin errors++; $display("FAIL reset_pxl_c got %0d exp 0", pxl_c); end
        rst = 1'b0;
        tick();
        write_px(8'd10, 4'd7);
        scan_line();
        for (int h = 0; h < 256; h++) begin
            checks++;
            if (got_a[h] !== 4'd0) begin errors++; $display("FAIL pre_valid_line0 h=%0d got %0d exp 0", h, got_a[h]); end
        end
        swap_line();
        scan_line();
        e = 4'd0;
        checks++; if (got_a[10] !== e) begin errors++; $display("FAIL pre_valid_a x10 got %0d exp 0", got_a[10]); end
        checks++; if (got_b[10] !== e) begin errors++; $display("FAIL pre_valid_b x10 got %0d exp 0", got_b[10]); end
        checks++; if (got_c[12] !== e) begin errors++; $display("FAIL pre_valid_c x10 got %0d exp 0", got_c[12]); end
        swap_line();
    endtask

    task automatic test_basic();
        logic [3:0] e;
        write_px(8'd10, 4'd5);
        write_px(8'd11, 4'd9);
        swap_line();
        scan_line();
        for (int h = 0; h < 256; h++) begin
            e = (h == 10) ? 4'd5 : (h == 11) ? 4'd9 : 4'd0;
            checks++;
            if (got_a[h] !== e) begin errors++; $display("FAIL basic_a h=%0d got %0d exp %0d", h, got_a[h], e); end
        end
        checks++; if (got_b[10] !== 4'd5) begin errors++; $display("FAIL basic_b x10 got %0d exp 5", got_b[10]); end
        checks++; if (got_c[12] !== 4'd5) begin errors++; $display("FAIL basic_c h12 got %0d exp 5", got_c[12]); end
        checks++; if (got_c[13] !== 4'd9) begin errors++; $display("FAIL basic_c h13 got %0d exp 9", got_c[13]); end
        checks++; if (got_c[10] !== 4'd0) begin errors++; $display("FAIL basic_c h10 got %0d exp 0", got_c[10]); end
    endtask

    task automatic test_priority();
        write_px(8'd20, 4'd3);
        write_px(8'd20, 4'd7);
        swap_line();
        scan_line();
        checks++; if (got_a[20] !== 4'd3) begin errors++; $display("FAIL prio_first x20 got %0d exp 3", got_a[20]); end
        checks++; if (got_b[20] !== 4'd7) begin errors++; $display("FAIL prio_last x20 got %0d exp 7", got_b[20]); end
        checks++; if (got_c[22] !== 4'd3) begin errors++; $display("FAIL prio_off h22 got %0d exp 3", got_c[22]); end
        swap_line();
        scan_line();
        swap_line();
        scan_line();
        checks++; if (got_a[20] !== 4'd0) begin errors++; $display("FAIL erase_a x20 got %0d exp 0", got_a[20]); end
        checks++; if (got_b[20] !== 4'd0) begin errors++; $display("FAIL erase_b x20 got %0d exp 0", got_b[20]); end
        checks++; if (got_c[22] !== 4'd0) begin errors++; $display("FAIL erase_c h22 got %0d exp 0", got_c[22]); end
    endtask

    task automatic test_transp_flip();
        write_px(8'd0, 4'd6);
        write_px(8'd0, 4'd0);
        tick();
        write_px(8'd0, 4'd0);
        swap_line();
        flip = 1'b1;
        scan_line();
        flip = 1'b0;
        checks++; if (got_a[255] !== 4'd6) begin errors++; $display("FAIL flip_a h255 got %0d exp 6", got_a[255]); end
        checks++; if (got_b[255] !== 4'd6) begin errors++; $display("FAIL flip_b h255 got %0d exp 6", got_b[255]); end
        checks++; if (got_a[0] !== 4'd0) begin errors++; $display("FAIL flip_a h0 got %0d exp 0", got_a[0]); end
        checks++; if (got_c[253] !== 4'd6) begin errors++; $display("FAIL flip_c h253 got %0d exp 6", got_c[253]); end
    endtask

    task automatic test_wrap_offset();
        write_px(8'd255, 4'd4);
        swap_line();
        scan_line();
        checks++; if (got_c[1] !== 4'd4) begin errors++; $display("FAIL wrap_c h1 got %0d exp 4", got_c[1]); end
        checks++; if (got_c[255] !== 4'd0) begin errors++; $display("FAIL wrap_c h255 got %0d exp 0", got_c[255]); end
        checks++; if (got_a[255] !== 4'd4) begin errors++; $display("FAIL wrap_a h255 got %0d exp 4", got_a[255]); end
    endtask

    task automatic test_swap_race();
        write_px(8'd30, 4'd8);
        wr_en = 1'b1; wr_addr = 8'd40; wr_pxl = 4'd2;
        pxl_cen = 1'b1; hinit = 1'b1; LHBL = 1'b0;
        tick();
        wr_en = 1'b0; pxl_cen = 1'b0; hinit = 1'b0;
        tick();
        scan_line();
        checks++; if (got_a[30] !== 4'd8) begin errors++; $display("FAIL race_cur_a x30 got %0d exp 8", got_a[30]); end
        checks++; if (got_a[40] !== 4'd0) begin errors++; $display("FAIL race_cur_a x40 got %0d exp 0", got_a[40]); end
        checks++; if (got_c[32] !== 4'd8) begin errors++; $display("FAIL race_cur_c h32 got %0d exp 8", got_c[32]); end
        swap_line();
        scan_line();
        checks++; if (got_a[40] !== 4'd2) begin errors++; $display("FAIL race_next_a x40 got %0d exp 2", got_a[40]); end
        checks++; if (got_b[40] !== 4'd2) begin errors++; $display("FAIL race_next_b x40 got %0d exp 2", got_b[40]); end
        checks++; if (got_c[42] !== 4'd2) begin errors++; $display("FAIL race_next_c h42 got %0d exp 2", got_c[42]); end
        checks++; if (got_a[30] !== 4'd0) begin errors++; $display("FAIL race_next_a x30 got %0d exp 0", got_a[30]); end
    endtask

    task automatic test_midline_reset();
        write_px(8'd10, 4'd5);
        swap_line();
        for (int h = 0; h <= 10; h++) begin
            pxl_cen = 1'b1; LHBL = 1'b1; hdump = 9'(h);
            tick();
            pxl_cen = 1'b0;
            tick();
        end
        checks++; if (pxl_a !== 4'd5) begin errors++; $display("FAIL midline_pre got %0d exp 5", pxl_a); end
        rst = 1'b1;
        #1;
        checks++; if (pxl_a !== 4'd0) begin errors++; $display("FAIL midline_async got %0d exp 0", pxl_a); end
        tick(); tick();
        rst = 1'b0; LHBL = 1'b0;
        tick();
        write_px(8'd100, 4'd7);
        scan_line();
        checks++; if (got_a[100] !== 4'd0) begin errors++; $display("FAIL midline_line0 x100 got %0d exp 0", got_a[100]); end
        swap_line();
        scan_line();
        checks++; if (got_a[100] !== 4'd0) begin errors++; $display("FAIL midline_line1 x100 got %0d exp 0", got_a[100]); end
        swap_line();
        write_px(8'd100, 4'd6);
        swap_line();
        scan_line();
        checks++; if (got_a[100] !== 4'd6) begin errors++; $display("FAIL midline_valid x100 got %0d exp 6", got_a[100]); end
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; hinit = 1'b0; LHBL = 1'b0; flip = 1'b0;
        wr_en = 1'b0; hdump = 9'd0; wr_addr = 8'd0; wr_pxl = 4'd0;
        test_reset();
        test_basic();
        test_priority();
        test_transp_flip();
        test_wrap_offset();
        test_swap_race();
        test_midline_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
